// File: rtl/rsa_pkg.sv
// rsa_pkg: state encoding and parameter helpers shared by the RSA modexp engine
package rsa_pkg;
    typedef enum logic [2:0] {IDLE, TOMONT, SQR, MUL, FROMMONT, OUT} state_t;
    function automatic int digits_of(input int n_bit, input int logr);
        return n_bit / logr;
    endfunction
    // multiplier latency: one cycle per digit plus the final conditional subtract
    function automatic int latency_of(input int n_bit, input int logr);
        return digits_of(n_bit, logr) + 1;
    endfunction
    function automatic bit params_ok(input longint n, input int n_bit, input int logr);
        return n[0] && (n < (longint'(1) << n_bit)) && (n_bit % logr == 0);
    endfunction
endpackage

// File: rtl/rsa_mont_mul.sv
// rsa_mont_mul: radix-2^LOGR Montgomery multiplier, result = a*b*R^-1 mod N
module rsa_mont_mul
    import rsa_pkg::*;
#(
    parameter int N_BIT = 12,
    parameter int LOGR = 3,
    parameter logic [N_BIT-1:0] N = 12'd3551,
    parameter logic [LOGR-1:0] P = 3'd1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N_BIT-1:0] a,
    input  logic [N_BIT-1:0] b,
    output logic             done,
    output logic [N_BIT-1:0] result
);
    localparam int W = N_BIT + LOGR + 2;
    localparam int L = latency_of(N_BIT, LOGR);
    localparam int CW = $clog2(L + 1);
    logic [W-1:0] t, t_cur, u, t_nxt;
    logic [N_BIT-1:0] a_sh, b_r, a_cur, b_cur;
    logic [LOGR-1:0] q;
    logic [CW-1:0] cnt;
    logic run;
    // the issue cycle already consumes digit 0 straight from the ports
    assign a_cur = start ? a : a_sh;
    assign b_cur = start ? b : b_r;
    assign t_cur = start ? '0 : t;
    assign u = t_cur + W'(a_cur[LOGR-1:0]) * W'(b_cur);
    assign q = u[LOGR-1:0] * P;
    assign t_nxt = (u + W'(q) * W'(N)) >> LOGR;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            t <= '0;
            a_sh <= '0;
            b_r <= '0;
            cnt <= '0;
            run <= 1'b0;
            done <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                t <= t_nxt;
                a_sh <= a >> LOGR;
                b_r <= b;
                cnt <= CW'(1);
                run <= 1'b1;
            end else if (run && cnt == CW'(L - 1)) begin
                result <= N_BIT'(t >= W'(N) ? t - W'(N) : t);
                done <= 1'b1;
                run <= 1'b0;
            end else if (run) begin
                t <= t_nxt;
                a_sh <= a_sh >> LOGR;
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/rsa_modexp.sv
// rsa_modexp: RSA modular exponentiation engine, encrypt/decrypt per transaction,
// left-to-right square-and-multiply over one shared Montgomery multiplier
module rsa_modexp
    import rsa_pkg::*;
#(
    parameter int N_BIT = 12,
    parameter int LOGR = 3,
    parameter logic [N_BIT-1:0] N = 12'd3551,
    parameter logic [LOGR-1:0] P = 3'd1,
    parameter logic [N_BIT-1:0] RMODN = 12'd545,
    parameter logic [N_BIT-1:0] R2MODN = 12'd2292,
    parameter int E_BIT = 12,
    parameter logic [E_BIT-1:0] E = 12'd5,
    parameter logic [E_BIT-1:0] D = 12'd1373,
    parameter bit CONST_TIME = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_BIT-1:0] in_data,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_BIT-1:0] out_data,
    output logic             out_err,
    output logic             busy
);
    localparam int IW = E_BIT > 1 ? $clog2(E_BIT) : 1;
    if (!params_ok(N, N_BIT, LOGR)) begin : g_bad_params
        $error("rsa_modexp: N must be odd and below 2^N_BIT, and N_BIT a multiple of LOGR");
    end
    state_t state, state_n;
    logic [N_BIT-1:0] x, xm, acc, mm_a, mm_b, mm_res;
    logic [E_BIT-1:0] exp_r;
    logic [IW-1:0] idx;
    logic issued, start, done, last, bit_set;
    assign in_ready = state == IDLE;
    assign out_valid = state == OUT;
    assign busy = state inside {TOMONT, SQR, MUL, FROMMONT};
    assign bit_set = exp_r[idx];
    assign last = idx == '0;
    // every busy state issues exactly one multiply on its first cycle
    assign start = busy && !issued;
    always_comb begin
        state_n = state;
        mm_a = acc;
        mm_b = acc;
        case (state)
            IDLE: state_n = in_valid ? (in_data >= N ? OUT : TOMONT) : IDLE;
            TOMONT: begin
                mm_a = x;
                mm_b = R2MODN;
                state_n = done ? SQR : TOMONT;
            end
            SQR: state_n = !done ? SQR : (bit_set || CONST_TIME) ? MUL : last ? FROMMONT : SQR;
            MUL: begin
                mm_b = xm;
                state_n = !done ? MUL : last ? FROMMONT : SQR;
            end
            FROMMONT: begin
                mm_b = N_BIT'(1);
                state_n = done ? OUT : FROMMONT;
            end
            OUT: state_n = out_ready ? IDLE : OUT;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            issued <= 1'b0;
        end else begin
            state <= state_n;
            issued <= start || (issued && !done);
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x <= '0;
            xm <= '0;
            acc <= '0;
            exp_r <= '0;
            idx <= '0;
            out_data <= '0;
            out_err <= 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                x <= in_data;
                exp_r <= mode ? D : E;
                acc <= RMODN;
                idx <= IW'(E_BIT - 1);
                out_data <= '0;
                out_err <= in_data >= N;
            end
            if (done && state == TOMONT) xm <= mm_res;
            // a multiply on a zero bit (constant-time schedule) is computed but discarded
            if (done && (state == SQR || (state == MUL && bit_set))) acc <= mm_res;
            if (done && ((state == SQR && !(bit_set || CONST_TIME)) || state == MUL)) idx <= idx - IW'(1);
            if (done && state == FROMMONT) out_data <= mm_res;
        end
    end
    rsa_mont_mul #(.N_BIT(N_BIT), .LOGR(LOGR), .N(N), .P(P)) u_mm (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .a(mm_a),
        .b(mm_b),
        .done(done),
        .result(mm_res)
    );
endmodule

// File: tb/tb_rsa_modexp.sv
// tb_rsa_modexp: directed scoreboard bench for rsa_modexp (default and constant-time builds)
module tb_rsa_modexp;
    localparam int NMOD = 3551;
    localparam int EXP_E = 5;
    localparam int EXP_D = 1373;
    typedef struct {
        logic [11:0] data;
        logic err;
        int lat;
    } exp_t;
    exp_t sb[$];
    logic clk = 0, rst_n = 0, in_valid = 0, mode = 0, out_ready = 1;
    logic ct_in_valid = 0, ct_out_ready = 1;
    logic [11:0] in_data = 0;
    logic in_ready, out_valid, out_err, busy;
    logic ct_in_ready, ct_out_valid, ct_out_err, ct_busy;
    logic [11:0] out_data, ct_out_data;
    int n_assert = 0, n_fail = 0;
    always #5 clk = ~clk;
    rsa_modexp dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err), .busy(busy)
    );
    rsa_modexp #(.CONST_TIME(1'b1)) dut_ct (
        .clk(clk), .rst_n(rst_n), .in_valid(ct_in_valid), .in_ready(ct_in_ready),
        .in_data(in_data), .mode(mode), .out_valid(ct_out_valid), .out_ready(ct_out_ready),
        .out_data(ct_out_data), .out_err(ct_out_err), .busy(ct_busy)
    );
    function automatic logic [11:0] modexp(input int b, input int e);
        longint r = 1;
        longint x = b % NMOD;
        for (int i = 11; i >= 0; i--) begin
            r = (r * r) % NMOD;
            if (e[i]) r = (r * x) % NMOD;
        end
        return 12'(r);
    endfunction
    function automatic int lat_of(input int e, input logic err);
        return err ? 1 : 6 * (2 + 12 + $countones(e)) + 1;
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask
    task automatic push(input logic [11:0] v, input logic m, input logic [11:0] expd);
        exp_t e;
        e.err = v >= 12'(NMOD);
        e.data = e.err ? 12'd0 : expd;
        e.lat = lat_of(m ? EXP_D : EXP_E, e.err);
        sb.push_back(e);
    endtask
    task automatic offer(input logic [11:0] v, input logic m, output int waited);
        int n = 0;
        in_data = v;
        mode = m;
        in_valid = 1;
        while (!in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) chk("accept", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 0;
        waited = n;
    endtask
    task automatic recv(input string tag, input int hold);
        exp_t e;
        int n = 1;
        logic [11:0] held;
        e = sb.pop_front();
        chk({tag, "_busy"}, 32'(busy), 32'(!e.err));
        while (!out_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(e.lat));
        chk({tag, "_data"}, 32'(out_data), 32'(e.data));
        chk({tag, "_err"}, 32'(out_err), 32'(e.err));
        held = out_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold"}, 32'({out_valid, in_ready, out_data}), 32'({2'b10, held}));
        end
        out_ready = 1;
        @(negedge clk);
    endtask
    task automatic ct_run(input string tag, input logic [11:0] v, input logic m, input logic [11:0] expd);
        int n = 1;
        in_data = v;
        mode = m;
        ct_in_valid = 1;
        chk({tag, "_rdy"}, 32'(ct_in_ready), 32'd1);
        @(negedge clk);
        ct_in_valid = 0;
        while (!ct_out_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'd157);
        chk({tag, "_data"}, 32'(ct_out_data), 32'(expd));
        chk({tag, "_err"}, 32'(ct_out_err), 32'd0);
        @(negedge clk);
    endtask
    initial begin
        int w, cnt;
        logic [11:0] c, v;
        logic [11:0] vals[$] = '{12'd0, 12'd1, 12'd2, 12'd3550};
        repeat (3) @(negedge clk);
        rst_n = 1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_ct_in_ready", 32'(ct_in_ready), 32'd1);
        push(12'd2, 1'b0, 12'd32);
        offer(12'd2, 1'b0, w);
        recv("enc2", 0);
        push(12'd32, 1'b1, 12'd2);
        offer(12'd32, 1'b1, w);
        recv("dec32", 0);
        for (int i = 0; i < 26; i++) vals.push_back(12'($urandom_range(3, 3549)));
        foreach (vals[i]) begin
            v = vals[i];
            c = modexp(int'(v), EXP_E);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push(v, 1'b0, c);
            offer(v, 1'b0, w);
            recv("enc", 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push(c, 1'b1, v);
            offer(c, 1'b1, w);
            recv("dec", 0);
        end
        push(12'd3551, 1'b0, 12'd0);
        offer(12'd3551, 1'b0, w);
        recv("err3551", 0);
        push(12'd4095, 1'b1, 12'd0);
        offer(12'd4095, 1'b1, w);
        recv("err4095", 0);
        // backpressure: a pending operand waits until the held result is taken
        push(12'd2, 1'b0, 12'd32);
        offer(12'd2, 1'b0, w);
        out_ready = 0;
        in_data = 12'd5;
        mode = 0;
        in_valid = 1;
        push(12'd5, 1'b0, 12'd3125);
        recv("bp", 20);
        offer(12'd5, 1'b0, w);
        chk("bp_accept_wait", 32'(w), 32'd0);
        recv("bp_next", 0);
        offer(12'd32, 1'b1, w);
        repeat (38) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        cnt = 0;
        repeat (140) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("midrst_no_out", 32'(cnt), 32'd0);
        push(12'd2, 1'b0, 12'd32);
        offer(12'd2, 1'b0, w);
        recv("enc_after_rst", 0);
        ct_run("ct_enc2", 12'd2, 1'b0, 12'd32);
        ct_run("ct_dec32", 12'd32, 1'b1, 12'd2);
        v = 12'd1234;
        c = modexp(int'(v), EXP_E);
        ct_run("ct_enc", v, 1'b0, c);
        ct_run("ct_dec", c, 1'b1, v);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
